// File: rtl/operand2_unit_pkg.sv
// Shared constants and types for the ARM shifter-operand unit.
package operand2_unit_pkg;

  // Shift type encodings, instr[6:5]
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Instruction field positions
  localparam int unsigned I_BIT         = 25;  // immediate operand flag
  localparam int unsigned REG_SHIFT_BIT = 4;   // register-specified shift when I=0
  localparam int unsigned RS_LSB        = 8;   // Rs index, 4 bits
  localparam int unsigned SHAMT_LSB     = 7;   // immediate shift amount, 5 bits
  localparam int unsigned TYPE_LSB      = 5;   // shift type, 2 bits
  localparam int unsigned ROT_LSB       = 8;   // rotate field, 4 bits
  localparam int unsigned IMM8_LSB      = 0;   // 8-bit immediate

  typedef enum logic [1:0] {
    StIdle,
    StFetchRs,
    StDone
  } state_e;

endpackage

// File: rtl/operand2_unit_shift_core.sv
// Combinational ARM barrel shifter covering immediate and register shift semantics.
module operand2_unit_shift_core
  import operand2_unit_pkg::*;
(
  input  logic [1:0]  sh_type,
  input  logic [7:0]  amount,
  input  logic        reg_mode,
  input  logic [31:0] value,
  input  logic        c_in,
  output logic [31:0] result,
  output logic        carry
);

  logic [4:0]  s;
  logic [32:0] lsl_ext;
  logic [32:0] lsr_ext;
  logic [32:0] asr_ext;
  logic [31:0] ror_res;
  logic        big;

  // Plain shifts for amounts 1..31; the extra bit catches the last bit shifted out
  always_comb begin
    s       = amount[4:0];
    lsl_ext = {1'b0, value} << s;
    lsr_ext = {value, 1'b0} >> s;
    asr_ext = 33'($signed({value, 1'b0}) >>> s);
    ror_res = (value >> s) | (value << (6'd32 - {1'b0, s}));
    big     = reg_mode && (amount[7:5] != 3'b000);
  end

  // Select the result according to amount special cases
  always_comb begin
    result = value;
    carry  = c_in;
    if (!reg_mode && (s == 5'd0)) begin
      // Immediate #0 encodings: LSR/ASR mean 32, ROR means RRX
      unique case (sh_type)
        SH_LSL: ;
        SH_LSR: begin
          result = 32'd0;
          carry  = value[31];
        end
        SH_ASR: begin
          result = {32{value[31]}};
          carry  = value[31];
        end
        SH_ROR: begin
          result = {c_in, value[31:1]};
          carry  = value[0];
        end
        default: ;
      endcase
    end else if (reg_mode && (amount == 8'd0)) begin
      result = value;
      carry  = c_in;
    end else if (big) begin
      unique case (sh_type)
        SH_LSL: begin
          result = 32'd0;
          carry  = (amount == 8'd32) ? value[0] : 1'b0;
        end
        SH_LSR: begin
          result = 32'd0;
          carry  = (amount == 8'd32) ? value[31] : 1'b0;
        end
        SH_ASR: begin
          result = {32{value[31]}};
          carry  = value[31];
        end
        SH_ROR: begin
          if (s == 5'd0) begin
            result = value;
            carry  = value[31];
          end else begin
            result = ror_res;
            carry  = ror_res[31];
          end
        end
        default: ;
      endcase
    end else begin
      unique case (sh_type)
        SH_LSL: begin
          result = lsl_ext[31:0];
          carry  = lsl_ext[32];
        end
        SH_LSR: begin
          result = lsr_ext[32:1];
          carry  = lsr_ext[0];
        end
        SH_ASR: begin
          result = asr_ext[32:1];
          carry  = asr_ext[0];
        end
        SH_ROR: begin
          result = ror_res;
          carry  = ror_res[31];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/operand2_unit.sv
// Sequential shifter-operand producer: handshake in, optional Rs fetch, registered result out.
module operand2_unit
  import operand2_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rm_val,
  input  logic        c_in,
  output logic        rs_req,
  output logic [3:0]  rs_addr,
  input  logic        rs_ack,
  input  logic [31:0] rs_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] op2,
  output logic        carry_out
);

  state_e      state_q, state_d;
  logic [1:0]  sh_type_q;
  logic [3:0]  rs_idx_q;
  logic [31:0] rm_q;
  logic        c_q;
  logic [31:0] op2_q, op2_d;
  logic        carry_q, carry_d;
  logic        latch, load;

  logic        fetching;
  logic [1:0]  core_type;
  logic [7:0]  core_amount;
  logic [31:0] core_value;
  logic        core_c;
  logic [31:0] core_result;
  logic        core_carry;

  logic [4:0]  rot_amt;
  logic [31:0] imm32;
  logic [31:0] rot_res;
  logic        rot_carry;

  logic        unused_bits;
  assign unused_bits = ^{instr[31:26], instr[24:12], rs_data[31:8]};

  // Feed the shifter from live inputs in IDLE and from latched operands while fetching Rs
  always_comb begin
    fetching    = (state_q == StFetchRs);
    core_type   = fetching ? sh_type_q : instr[TYPE_LSB +: 2];
    core_amount = fetching ? rs_data[7:0] : {3'b000, instr[SHAMT_LSB +: 5]};
    core_value  = fetching ? rm_q : rm_val;
    core_c      = fetching ? c_q : c_in;
  end

  operand2_unit_shift_core u_shift_core (
    .sh_type  (core_type),
    .amount   (core_amount),
    .reg_mode (fetching),
    .value    (core_value),
    .c_in     (core_c),
    .result   (core_result),
    .carry    (core_carry)
  );

  // Rotated 8-bit immediate; a zero rotate leaves the C flag untouched
  always_comb begin
    rot_amt   = {instr[ROT_LSB +: 4], 1'b0};
    imm32     = {24'd0, instr[IMM8_LSB +: 8]};
    rot_res   = (imm32 >> rot_amt) | (imm32 << (6'd32 - {1'b0, rot_amt}));
    rot_carry = (rot_amt == 5'd0) ? c_in : rot_res[31];
  end

  // Next-state and result-load decisions
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    load    = 1'b0;
    op2_d   = core_result;
    carry_d = core_carry;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          latch = 1'b1;
          if (!instr[I_BIT] && instr[REG_SHIFT_BIT]) begin
            state_d = StFetchRs;
          end else begin
            state_d = StDone;
            load    = 1'b1;
            if (instr[I_BIT]) begin
              op2_d   = rot_res;
              carry_d = rot_carry;
            end
          end
        end
      end
      StFetchRs: begin
        if (rs_ack) begin
          state_d = StDone;
          load    = 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, operand latches and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sh_type_q <= 2'b00;
      rs_idx_q  <= 4'd0;
      rm_q      <= 32'd0;
      c_q       <= 1'b0;
      op2_q     <= 32'd0;
      carry_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        sh_type_q <= instr[TYPE_LSB +: 2];
        rs_idx_q  <= instr[RS_LSB +: 4];
        rm_q      <= rm_val;
        c_q       <= c_in;
      end
      if (load) begin
        op2_q   <= op2_d;
        carry_q <= carry_d;
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign rs_req    = (state_q == StFetchRs);
  assign out_valid = (state_q == StDone);
  assign rs_addr   = rs_idx_q;
  assign op2       = op2_q;
  assign carry_out = carry_q;

endmodule

// File: doc/operand2_unit.md
# operand2_unit

Sequential producer of the ARM data-processing second operand (shifter operand) and shifter carry-out for the CPU execute stage. It accepts an instruction word plus the Rm value over a valid/ready handshake. For register-specified shifts it initiates a register-file read of Rs over a req/ack port. It applies full ARM shift semantics and presents operand2 and carry over a valid/ready output handshake.

## Interface
Parameters: none; all widths are fixed by the ISA.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- instr  in  32  instruction; bit 25 is I, bits 11:0 are the operand2 field
- rm_val  in  32  value of Rm, i.e. instr[3:0]
- c_in  in  1  current CPSR C flag
- rs_req  out  1  Rs read request
- rs_addr  out  4  Rs index, equal to instr[11:8]
- rs_ack  in  1  read complete; rs_data is valid in the same cycle
- rs_data  in  32  Rs value
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- op2  out  32  shifted or rotated operand
- carry_out  out  1  shifter carry-out

## Operation
- States: IDLE, FETCH_RS, DONE.
  - IDLE: in_ready=1. On in_valid, latch instr, rm_val and c_in.
    - If I=0 and instr[4]=1 (register shift), go to FETCH_RS.
    - Otherwise compute the result and go to DONE.
  - FETCH_RS: rs_req=1, with rs_addr held stable, until rs_ack. On rs_ack, compute with n=rs_data[7:0] and go to DONE.
  - DONE: out_valid=1, with op2 and carry_out held stable. When out_ready=1, go to IDLE.
- Shift type is instr[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- Immediate shift, with amount k=instr[11:7]:
  - LSL #0 gives rm, carry=c_in.
  - LSR #0 and ASR #0 mean a shift of 32.
  - ROR #0 is RRX: {c_in, rm[31:1]}, carry=rm[0].
  - For k=1..31, use the normal shift; carry is the last bit shifted out.
- Register shift, with amount n=Rs[7:0]:
  - n=0 (any type) gives rm, carry=c_in.
  - LSL: n=32 gives 0 with carry rm[0]. n>32 gives 0 with carry 0.
  - LSR: n=32 gives 0 with carry rm[31]. n>32 gives 0 with carry 0.
  - ASR: n≥32 gives a result of all bits equal to rm[31], with carry rm[31].
  - ROR: if n[4:0]=0, the result is rm with carry rm[31]. Otherwise rotate by n[4:0], with carry rm[n[4:0]-1].
- Rotated immediate (I=1): op2 = instr[7:0] rotated right by 2*instr[11:8].
  - carry = c_in if the rotate is 0, else op2[31].
- rs_ack is ignored outside FETCH_RS. rs_data is not used for immediate forms.

## Timing
- Reset values: in_ready=1, rs_req=0, rs_addr=0, out_valid=0, op2=0, carry_out=0. State is IDLE.
- Immediate and rotated forms: request accepted in cycle t; out_valid=1 in cycle t+1.
- Register-shift forms:
  - rs_req rises in cycle t+1 and stays high through the ack cycle.
  - If rs_ack arrives in cycle t+a, out_valid=1 in cycle t+a+1.
  - rs_req deasserts in the cycle after ack.
- in_ready=1 only in IDLE, so there is no overlap of requests. Throughput is at most one result per 2 cycles.
- Under backpressure (out_ready=0), outputs hold indefinitely.
- An asynchronous reset in any state immediately clears rs_req and out_valid. A late rs_ack after reset is ignored.
- op2 and carry_out are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - shift-type constants SH_LSL, SH_LSR, SH_ASR, SH_ROR (2-bit)
  - the state enum
  - field position constants for I, instr[4], Rs, shift amount, rotate and imm8
- One combinational sub-module, shift_core. Inputs: type, 8-bit amount, reg_mode flag, 32-bit value, c_in. Outputs: result, carry. It implements all of the immediate and register semantics above.
- operand2_unit contains the FSM, the latches, the rotated-immediate path and the output registers.

## Test plan
- Immediate LSL #4 (instr[11:7]=4, [6:4]=000), rm=0x8000000F, c_in=0 → op2=0x000000F0, carry=0, out_valid in cycle t+1.
- Immediate ROR #0 (RRX), rm=0x00000003, c_in=1 → op2=0x80000001, carry=1. LSR #0 with rm=0x80000000 → op2=0, carry=1.
- Register LSR with Rs=0x00000120 (n=32), rm=0x80000000, rs_ack delayed 3 cycles:
  - rs_req and rs_addr stay stable for the whole wait.
  - Result is op2=0, carry=1.
  - rs_req drops the cycle after ack.
- Register ASR:
  - Rs=0xFF, rm=0x80000001 → 0xFFFFFFFF, carry=1.
  - Rs=0x100 (n=0), c_in=1 → op2=rm, carry=1.
  - ROR with Rs=0x20 → op2=rm, carry=rm[31].
- Rotated immediate:
  - rot=1, imm8=0xFF → 0xC000003F, carry=1.
  - rot=0, imm8=0x12, c_in=1 → 0x00000012, carry=1.
- Control and reset:
  - out_ready held low 5 cycles → op2 and carry_out stable, in_ready=0.
  - rst_n pulsed low during FETCH_RS → rs_req=0 and out_valid=0 immediately.
  - A subsequent stray rs_ack produces no output.
